hf_line_store: RTL

Frequency-line store that sits directly downstream of the per-table Huffman pair decoders in the MP3 parser. It accepts decoded (x, y) pairs for one granule/channel with no backpressure, writes them as lines 2k and 2k+1, and zero-fills every line past the big_values region. Once all 576 lines are written it signals completion and serves random-access reads to the requantizer. Count1 quadruples are out of scope for this revision; their lines read back as zero.

---
 rtl/hf_line_store.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/hf_line_store.sv
// Frequency-line store fed by the Huffman pair decoders: collects big_values pairs,
// zero-fills the remaining lines of the granule, then serves 1-cycle random-access reads.
module hf_line_store #(
    parameter int NUM_PAIRS = 288,
    parameter int DATA_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic [8:0]               i_big_values,
    input  logic                     i_pair_valid,
    input  logic signed [DATA_W-1:0] i_x_val,
    input  logic signed [DATA_W-1:0] i_y_val,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [8:0]               o_pairs_written,
    input  logic                     i_rd_en,
    input  logic [9:0]               i_rd_addr,
    output logic                     o_rd_valid,
    output logic signed [DATA_W-1:0] o_rd_data,
    output logic [1:0]               o_state
);

    localparam int NUM_LINES = 2 * NUM_PAIRS;
    localparam logic [8:0] LP_NP   = 9'(NUM_PAIRS);
    localparam logic [8:0] LP_LAST = 9'(NUM_PAIRS - 1);
    localparam logic [9:0] LP_NL   = 10'(NUM_LINES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_ZERO    = 2'd2;
    localparam logic [1:0] S_READY   = 2'd3;

    // Handshake: i_pair_valid is a bare strobe with no ready; every strobe seen in
    // COLLECT (and not alongside i_start) is written, anything else only flags o_err.

    logic [1:0]               r_state;
    logic [8:0]               r_bv;
    logic [8:0]               r_pw;
    logic                     r_done;
    logic                     r_err;
    logic                     r_rd_valid;
    logic signed [DATA_W-1:0] r_rd_data;

    logic signed [DATA_W-1:0] r_mem_even [NUM_PAIRS];
    logic signed [DATA_W-1:0] r_mem_odd  [NUM_PAIRS];

    logic                     w_we;
    logic signed [DATA_W-1:0] w_wx;
    logic signed [DATA_W-1:0] w_wy;
    logic [8:0]               w_bv;
    logic                     w_over;
    logic                     w_pv_err;
    logic                     w_rd_err;
    logic [8:0]               w_rd_idx;

    assign w_over   = (i_big_values > LP_NP);
    assign w_bv     = w_over ? LP_NP : i_big_values;
    assign w_pv_err = i_pair_valid && (i_start || (r_state != S_COLLECT));
    assign w_rd_err = i_rd_en && (r_state != S_READY);
    assign w_rd_idx = i_rd_addr[9:1];

    // Zero-fill shares the pair write port; a start in the same cycle wins.
    always_comb begin
        w_we = 1'b0;
        w_wx = '0;
        w_wy = '0;
        if (!rst && !i_start) begin
            if (r_state == S_COLLECT && i_pair_valid) begin
                w_we = 1'b1;
                w_wx = i_x_val;
                w_wy = i_y_val;
            end else if (r_state == S_ZERO) begin
                w_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_even[r_pw] <= w_wx;
            r_mem_odd[r_pw]  <= w_wy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bv       <= '0;
            r_pw       <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;

            if (i_start) begin
                r_bv    <= w_bv;
                r_pw    <= '0;
                r_err   <= w_over | w_pv_err | w_rd_err;
                r_state <= (w_bv == '0) ? S_ZERO : S_COLLECT;
            end else begin
                if (w_pv_err || w_rd_err) r_err <= 1'b1;
                case (r_state)
                    S_COLLECT: begin
                        if (i_pair_valid) begin
                            r_pw <= r_pw + 9'd1;
                            if (r_pw + 9'd1 == r_bv) begin
                                if (r_bv == LP_NP) begin
                                    r_state <= S_READY;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= S_ZERO;
                                end
                            end
                        end
                    end
                    S_ZERO: begin
                        r_pw <= r_pw + 9'd1;
                        if (r_pw == LP_LAST) begin
                            r_state <= S_READY;
                            r_done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end

            if (i_rd_en && r_state == S_READY) begin
                r_rd_valid <= 1'b1;
                if (i_rd_addr < LP_NL)
                    r_rd_data <= i_rd_addr[0] ? r_mem_odd[w_rd_idx] : r_mem_even[w_rd_idx];
            end
        end
    end

    assign o_busy          = (r_state == S_COLLECT) || (r_state == S_ZERO);
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_pairs_written = r_pw;
    assign o_rd_valid      = r_rd_valid;
    assign o_rd_data       = r_rd_data;
    assign o_state         = r_state;

endmodule
